// File: rtl/regfile_access_arbiter.sv
// ============================================================================
// Module      : regfile_access_arbiter
// Description : Write/read port arbiter for the card regfile. It serves two
//               write requesters, a full-deck read sweep and single-card reads.
//               Define REGFILE_ARB_RR_EN to select round-robin write
//               arbitration. The default is fixed priority w0 > w1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_access_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int MAX_CARDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   num_of_cards,
    input  logic              w0_req,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    output logic              w0_ack,
    input  logic              w1_req,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w1_ack,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic              sweep_valid,
    output logic [ADDR_W-1:0] sweep_idx,
    output logic              sweep_done,
    input  logic              one_req,
    input  logic [ADDR_W-1:0] one_addr,
    output logic              one_valid,
    output logic [ADDR_W-1:0] rf_r_addr
);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_sweep      = 3'd1;
    localparam logic [2:0] c_st_sweep_tail = 3'd2;
    localparam logic [2:0] c_st_one        = 3'd3;
    localparam logic [2:0] c_st_one_wait   = 3'd4;

    localparam logic [ADDR_W:0]   c_max_cards = (ADDR_W+1)'(MAX_CARDS);
    localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    logic w_grant0;
    logic w_grant1;

`ifdef REGFILE_ARB_RR_EN
    // r_prio_w1 marks w1 as the preferred requester on the next collision
    logic r_prio_w1;

    always_comb begin
        w_grant1 = w1_req && (!w0_req || r_prio_w1);
        w_grant0 = w0_req && !w_grant1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_w1 <= 1'b0;
        end else if (w_grant0) begin
            r_prio_w1 <= 1'b1;
        end else if (w_grant1) begin
            r_prio_w1 <= 1'b0;
        end
    end
`else
    assign w_grant0 = w0_req;
    assign w_grant1 = w1_req && !w0_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_w_en   <= 1'b0;
            rf_w_addr <= '0;
            rf_w_data <= '0;
            w0_ack    <= 1'b0;
            w1_ack    <= 1'b0;
        end else begin
            rf_w_en <= 1'b0;
            w0_ack  <= 1'b0;
            w1_ack  <= 1'b0;
            if (w_grant0) begin
                rf_w_en   <= 1'b1;
                rf_w_addr <= w0_addr;
                rf_w_data <= w0_data;
                w0_ack    <= 1'b1;
            end else if (w_grant1) begin
                rf_w_en   <= 1'b1;
                rf_w_addr <= w1_addr;
                rf_w_data <= w1_data;
                w1_ack    <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read sequencing
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [ADDR_W:0] r_cnt;
    logic [ADDR_W:0] r_last;
    logic [ADDR_W:0] w_n_clamped;

    assign w_n_clamped = (num_of_cards > c_max_cards) ? c_max_cards : num_of_cards;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_last      <= '0;
            rf_r_addr   <= '0;
            sweep_busy  <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_idx   <= '0;
            sweep_done  <= 1'b0;
            one_valid   <= 1'b0;
        end else begin
            sweep_valid <= 1'b0;
            sweep_done  <= 1'b0;
            one_valid   <= 1'b0;
            // busy covers the sweep_done cycle and drops right after it
            if (sweep_done) begin
                sweep_busy <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (sweep_start) begin
                        sweep_busy <= 1'b1;
                        if (w_n_clamped == '0) begin
                            sweep_done <= 1'b1;
                        end else begin
                            r_last    <= w_n_clamped - c_cnt_one;
                            r_cnt     <= '0;
                            rf_r_addr <= '0;
                            r_state   <= c_st_sweep;
                        end
                    end else if (one_req) begin
                        rf_r_addr <= one_addr;
                        r_state   <= c_st_one;
                    end
                end
                c_st_sweep: begin
                    // rf_r_addr now addresses card r_cnt; its data arrives next cycle
                    sweep_valid <= 1'b1;
                    sweep_idx   <= rf_r_addr;
                    if (r_cnt == r_last) begin
                        r_state <= c_st_sweep_tail;
                    end else begin
                        r_cnt     <= r_cnt + c_cnt_one;
                        rf_r_addr <= rf_r_addr + c_addr_one;
                    end
                end
                c_st_sweep_tail: begin
                    sweep_done <= 1'b1;
                    r_state    <= c_st_idle;
                end
                c_st_one: begin
                    one_valid <= 1'b1;
                    r_state   <= c_st_one_wait;
                end
                c_st_one_wait: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_arbiter.sv
// ============================================================================
// Module      : tb_regfile_access_arbiter
// Description : Scoreboard bench for regfile_access_arbiter with a regfile model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_access_arbiter;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int MAX_CARDS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W:0]   num_of_cards;
    logic              w0_req, w1_req, w0_ack, w1_ack;
    logic [ADDR_W-1:0] w0_addr, w1_addr;
    logic [DATA_W-1:0] w0_data, w1_data;
    logic              rf_w_en;
    logic [ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic              sweep_start, sweep_busy, sweep_valid, sweep_done;
    logic [ADDR_W-1:0] sweep_idx;
    logic              one_req, one_valid;
    logic [ADDR_W-1:0] one_addr, rf_r_addr;

    logic [DATA_W-1:0] mem   [0:MAX_CARDS-1];
    logic [DATA_W-1:0] model [0:MAX_CARDS-1];
    logic [DATA_W-1:0] rf_r_data;

    typedef struct packed {
        logic              who;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t wq[$];
    int  sq[$];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    regfile_access_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_CARDS (MAX_CARDS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .num_of_cards (num_of_cards),
        .w0_req       (w0_req),
        .w0_addr      (w0_addr),
        .w0_data      (w0_data),
        .w0_ack       (w0_ack),
        .w1_req       (w1_req),
        .w1_addr      (w1_addr),
        .w1_data      (w1_data),
        .w1_ack       (w1_ack),
        .rf_w_en      (rf_w_en),
        .rf_w_addr    (rf_w_addr),
        .rf_w_data    (rf_w_data),
        .sweep_start  (sweep_start),
        .sweep_busy   (sweep_busy),
        .sweep_valid  (sweep_valid),
        .sweep_idx    (sweep_idx),
        .sweep_done   (sweep_done),
        .one_req      (one_req),
        .one_addr     (one_addr),
        .one_valid    (one_valid),
        .rf_r_addr    (rf_r_addr)
    );

    // Regfile: synchronous write and read, read returns pre-write contents
    always @(posedge clk) begin
        if (rf_w_en) mem[rf_w_addr] <= rf_w_data;
        rf_r_data <= mem[rf_r_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({w0_ack, w1_ack, rf_w_en, rf_w_addr, rf_w_data, sweep_busy, sweep_valid,
             sweep_idx, sweep_done, one_valid, rf_r_addr} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got w0_ack=%b w1_ack=%b w_en=%b busy=%b valid=%b done=%b one_valid=%b r_addr=%0d, want all 0",
                     w0_ack, w1_ack, rf_w_en, sweep_busy, sweep_valid, sweep_done, one_valid, rf_r_addr);
        end
    endtask

    task automatic write_card(input logic who, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        int  c;
        e.who = who; e.addr = a; e.data = d;
        wq.push_back(e);
        if (who) begin w1_req = 1'b1; w1_addr = a; w1_data = d; end
        else     begin w0_req = 1'b1; w0_addr = a; w0_data = d; end
        c = 0;
        while (wq.size() != 0 && c < 8) begin
            tick;
            c++;
            if (rf_w_en) begin
                e = wq.pop_front();
                if (w0_ack) w0_req = 1'b0;
                if (w1_ack) w1_req = 1'b0;
                checks++;
                if ({rf_w_addr, rf_w_data, w0_ack, w1_ack} !== {e.addr, e.data, !e.who, e.who} || c != 1) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%0h ack0=%b ack1=%b cyc=%0d, want addr=%0d data=%0h who=%0b cyc=1",
                             rf_w_addr, rf_w_data, w0_ack, w1_ack, c, e.addr, e.data, e.who);
                end
                model[e.addr] = e.data;
            end
        end
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL write_timeout: got no write within %0d cycles, want one", c);
        end
        wq.delete();
        w0_req = 1'b0;
        w1_req = 1'b0;
    endtask

    task automatic test_single_write;
        write_card(1'b0, 5'd3, 8'h5A);
        tick;
        checks++;
        if (rf_w_en !== 1'b0 || w0_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_write_extra: got w_en=%b ack=%b, want 0 0", rf_w_en, w0_ack);
        end
    endtask

    task automatic test_collision(input logic first_w1);
        wr_t e0, e1, e;
        int  n, c;
        e0.who = 1'b0; e0.addr = 5'd1; e0.data = 8'h11;
        e1.who = 1'b1; e1.addr = 5'd2; e1.data = 8'h22;
        if (first_w1) begin wq.push_back(e1); wq.push_back(e0); end
        else          begin wq.push_back(e0); wq.push_back(e1); end
        w0_req = 1'b1; w0_addr = e0.addr; w0_data = e0.data;
        w1_req = 1'b1; w1_addr = e1.addr; w1_data = e1.data;
        n = 0;
        c = 0;
        while (wq.size() != 0 && c < 6) begin
            tick;
            c++;
            if (rf_w_en) begin
                e = wq.pop_front();
                checks++;
                if ({rf_w_addr, rf_w_data, w0_ack, w1_ack} !== {e.addr, e.data, !e.who, e.who} || c != n + 1) begin
                    errors++;
                    $display("FAIL collision: got addr=%0d data=%0h ack0=%b ack1=%b cyc=%0d, want addr=%0d data=%0h who=%0b cyc=%0d",
                             rf_w_addr, rf_w_data, w0_ack, w1_ack, c, e.addr, e.data, e.who, n + 1);
                end
                model[e.addr] = e.data;
                if (w0_ack) w0_req = 1'b0;
                if (w1_ack) w1_req = 1'b0;
                n++;
            end
        end
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL collision_timeout: got %0d writes, want 2", n);
        end
        wq.delete();
        w0_req = 1'b0;
        w1_req = 1'b0;
        tick;
    endtask

    task automatic test_sweep(input int n_in, input int exp_n);
        int done_c, e_idx, want_done;
        sq.delete();
        for (int i = 0; i < exp_n; i++) sq.push_back(i);
        num_of_cards = (ADDR_W+1)'(n_in);
        sweep_start  = 1'b1;
        done_c = -1;
        for (int c = 1; c <= exp_n + 5; c++) begin
            tick;
            if (c == 1) begin
                sweep_start = 1'b0;
                checks++;
                if (sweep_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_busy_start: got %b, want 1", sweep_busy);
                end
            end
            if (sweep_valid) begin
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL sweep_extra_valid: got valid idx=%0d at cyc %0d, want none", sweep_idx, c);
                end else begin
                    e_idx = sq.pop_front();
                    if (sweep_idx !== 5'(e_idx) || rf_r_data !== model[e_idx] || c != e_idx + 2) begin
                        errors++;
                        $display("FAIL sweep_data: got idx=%0d data=%0h cyc=%0d, want idx=%0d data=%0h cyc=%0d",
                                 sweep_idx, rf_r_data, c, e_idx, model[e_idx], e_idx + 2);
                    end
                end
            end
            if (sweep_done) begin
                if (done_c < 0) done_c = c;
                else begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_done_repeat: got second done at cyc %0d, want one", c);
                end
            end
        end
        want_done = (exp_n == 0) ? 1 : exp_n + 2;
        checks++;
        if (done_c != want_done) begin
            errors++;
            $display("FAIL sweep_done_cycle: got %0d, want %0d (N=%0d)", done_c, want_done, n_in);
        end
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL sweep_missing: got %0d valids missing, want 0", sq.size());
        end
        checks++;
        if (sweep_busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_busy_end: got %b, want 0", sweep_busy);
        end
    endtask

    task automatic test_one_idle(input logic [ADDR_W-1:0] a);
        int vc;
        one_req  = 1'b1;
        one_addr = a;
        vc = -1;
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (one_valid && vc < 0) begin
                vc = c;
                one_req = 1'b0;
                checks++;
                if (rf_r_data !== model[a]) begin
                    errors++;
                    $display("FAIL one_data: got %0h, want %0h (addr %0d)", rf_r_data, model[a], a);
                end
            end
        end
        one_req = 1'b0;
        checks++;
        if (vc != 2) begin
            errors++;
            $display("FAIL one_latency: got %0d, want 2", vc);
        end
    endtask

    task automatic test_one_during_sweep;
        int done_c, vc;
        num_of_cards = 6'd16;
        sweep_start  = 1'b1;
        tick;
        sweep_start = 1'b0;
        tick;
        one_req  = 1'b1;
        one_addr = 5'd7;
        done_c = -1;
        vc     = -1;
        for (int c = 3; c <= 30; c++) begin
            tick;
            if (sweep_done && done_c < 0) done_c = c;
            if (one_valid && vc < 0) begin
                vc = c;
                one_req = 1'b0;
                checks++;
                if (rf_r_data !== model[7]) begin
                    errors++;
                    $display("FAIL one_in_sweep_data: got %0h, want %0h", rf_r_data, model[7]);
                end
            end
        end
        one_req = 1'b0;
        checks++;
        if (done_c != 18 || vc != 20) begin
            errors++;
            $display("FAIL one_in_sweep_timing: got done=%0d valid=%0d, want done=18 valid=20", done_c, vc);
        end
    endtask

    task automatic test_same_addr;
        logic [DATA_W-1:0] old_v;
        old_v    = model[5];
        one_req  = 1'b1; one_addr = 5'd5;
        w0_req   = 1'b1; w0_addr  = 5'd5; w0_data = 8'hC3;
        tick;
        checks++;
        if (rf_w_en !== 1'b1 || w0_ack !== 1'b1 || rf_r_addr !== 5'd5) begin
            errors++;
            $display("FAIL same_addr_issue: got w_en=%b ack=%b r_addr=%0d, want 1 1 5", rf_w_en, w0_ack, rf_r_addr);
        end
        w0_req = 1'b0;
        tick;
        checks++;
        if (one_valid !== 1'b1 || rf_r_data !== old_v) begin
            errors++;
            $display("FAIL same_addr_old_data: got valid=%b data=%0h, want 1 %0h", one_valid, rf_r_data, old_v);
        end
        one_req  = 1'b0;
        model[5] = 8'hC3;
        tick;
        test_one_idle(5'd5);
    endtask

    task automatic test_reset_mid_sweep;
        int bad;
        num_of_cards = 6'd16;
        sweep_start  = 1'b1;
        tick;
        sweep_start = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        tick;
        test_reset;
        rst = 1'b0;
        bad = 0;
        repeat (24) begin
            tick;
            if (sweep_valid || sweep_done || sweep_busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d cycles of sweep activity after reset, want 0", bad);
        end
        test_sweep(16, 16);
    endtask

    initial begin
        rst = 1'b1;
        num_of_cards = '0;
        w0_req = 1'b0; w0_addr = '0; w0_data = '0;
        w1_req = 1'b0; w1_addr = '0; w1_data = '0;
        sweep_start = 1'b0;
        one_req = 1'b0; one_addr = '0;
        tick;
        tick;
        test_reset;
        rst = 1'b0;
        tick;

        for (int i = 0; i < MAX_CARDS; i++)
            write_card((i % 2) == 1, 5'(i), 8'(8'hA0 ^ (i * 7)));
        test_single_write;

        write_card(1'b1, 5'd9, 8'h99);
        test_collision(1'b0);
        write_card(1'b0, 5'd10, 8'h10);
`ifdef REGFILE_ARB_RR_EN
        test_collision(1'b1);
`else
        test_collision(1'b0);
`endif

        test_sweep(16, 16);
        test_sweep(0, 0);
        test_sweep(40, 32);
        test_sweep(1, 1);
        test_one_idle(5'd12);
        test_one_during_sweep;
        tick;
        test_same_addr;
        test_reset_mid_sweep;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
